// File: rtl/central_config_fsm_pkg.sv
// Shared types for the central controller: run states, editor fields, keypad codes.
// The digit helper separates numeric keys from command keys.
package central_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_SIM    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ENDING = 2'd3
    } sim_state_e;

    typedef enum logic [1:0] {
        SET_PEOPLE    = 2'd0,
        SET_ALGORITHM = 2'd1,
        SET_SIMSPEED  = 2'd2
    } setting_e;

    typedef enum logic [3:0] {
        BTN_STOP   = 4'hA,
        BTN_RESUME = 4'hB,
        BTN_UP     = 4'hC,
        BTN_DOWN   = 4'hD,
        BTN_ESCAPE = 4'hE,
        BTN_ENTER  = 4'hF
    } button_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/central_config_fsm_digit_accumulator.sv
// Decimal entry register: appends a digit (x10+d) only when the result stays within limit.
// Clear has priority over add; rejected digits leave the value untouched.
module digit_accumulator
    import central_pkg::*;
#(
    parameter int NUM_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_W+3:0]    limit,
    input  logic                add,
    input  logic [3:0]          digit,
    input  logic                clear,
    output logic [NUM_W-1:0]    number
);

    logic [NUM_W-1:0] number_reg;
    logic [NUM_W-1:0] number_next;
    logic [NUM_W+3:0] wide_num;
    logic [NUM_W+3:0] cand;

    // Four extra bits hold 10*(2**NUM_W-1)+9 without overflow.
    assign wide_num = {4'd0, number_reg};
    assign cand     = (wide_num << 3) + (wide_num << 1) + {{NUM_W{1'b0}}, digit};

    always_comb begin
        number_next = number_reg;
        if (clear) begin
            number_next = '0;
        end else if (add && (cand <= limit)) begin
            number_next = cand[NUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_reg <= '0;
        end else begin
            number_reg <= number_next;
        end
    end

    assign number = number_reg;

endmodule

// File: rtl/central_config_fsm.sv
// Central controller: run-state FSM plus keypad settings editor with commit/cancel.
// Optional idle discard of partial entry is enabled by defining ENTRY_TIMEOUT_EN.
module central_config_fsm
    import central_pkg::*;
#(
    parameter int NUM_W       = 6,
    parameter int MAX_PEOPLE  = 40,
    parameter int DEF_PEOPLE  = 8,
    parameter int NUM_ALGOS   = 4,
    parameter int SPEED_W     = 3,
    parameter int DEF_SPEED   = 1,
    parameter int TIMEOUT_CYC = 1000,
    localparam int ALGO_W     = (NUM_ALGOS > 1) ? $clog2(NUM_ALGOS) : 1,
    localparam int MAX_SPEED  = (1 << SPEED_W) - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         button_bus,
    input  logic               pressed,
    output logic [1:0]         sim_state,
    output logic [1:0]         setting,
    output logic [NUM_W-1:0]   people,
    output logic [ALGO_W-1:0]  algorithm,
    output logic [SPEED_W-1:0] sim_speed,
    output logic [NUM_W-1:0]   number,
    output logic               commit,
    output logic               entry_timeout
);

    sim_state_e          state_reg, state_next;
    setting_e            setting_reg, setting_next;
    logic [NUM_W-1:0]    people_reg, people_next;
    logic [ALGO_W-1:0]   algorithm_reg, algorithm_next;
    logic [SPEED_W-1:0]  speed_reg, speed_next;
    logic                commit_reg, commit_next;
    logic                timeout_reg;
    logic                pressed_q;
    logic                key_evt;
    logic                timeout_fire;
    logic                acc_add, acc_clear;
    logic [NUM_W+3:0]    limit;

    assign key_evt = pressed & ~pressed_q;

    always_comb begin
        case (setting_reg)
            SET_PEOPLE:    limit = (NUM_W+4)'(MAX_PEOPLE);
            SET_ALGORITHM: limit = (NUM_W+4)'(NUM_ALGOS - 1);
            SET_SIMSPEED:  limit = (NUM_W+4)'(MAX_SPEED);
            default:       limit = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        setting_next   = setting_reg;
        people_next    = people_reg;
        algorithm_next = algorithm_reg;
        speed_next     = speed_reg;
        commit_next    = 1'b0;
        acc_add        = 1'b0;
        // Entry only lives in START; an idle expiry also discards it.
        acc_clear      = (state_reg != ST_START) | timeout_fire;
        if (key_evt) begin
            case (state_reg)
                ST_START: begin
                    if (is_digit(button_bus)) begin
                        acc_add = 1'b1;
                    end else begin
                        case (button_bus)
                            BTN_RESUME: begin
                                state_next = ST_SIM;
                                acc_clear  = 1'b1;
                            end
                            BTN_UP: begin
                                acc_clear = 1'b1;
                                case (setting_reg)
                                    SET_PEOPLE:    setting_next = SET_ALGORITHM;
                                    SET_ALGORITHM: setting_next = SET_SIMSPEED;
                                    default:       setting_next = SET_PEOPLE;
                                endcase
                            end
                            BTN_DOWN: begin
                                acc_clear = 1'b1;
                                case (setting_reg)
                                    SET_PEOPLE:    setting_next = SET_SIMSPEED;
                                    SET_SIMSPEED:  setting_next = SET_ALGORITHM;
                                    default:       setting_next = SET_PEOPLE;
                                endcase
                            end
                            BTN_ESCAPE: acc_clear = 1'b1;
                            BTN_ENTER: begin
                                acc_clear   = 1'b1;
                                commit_next = 1'b1;
                                case (setting_reg)
                                    SET_PEOPLE:    people_next    = number;
                                    SET_ALGORITHM: algorithm_next = ALGO_W'(number);
                                    default:       speed_next     = SPEED_W'(number);
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SIM:    if (button_bus == BTN_STOP)   state_next = ST_PAUSE;
                ST_PAUSE: begin
                    if (button_bus == BTN_RESUME)        state_next = ST_SIM;
                    else if (button_bus == BTN_STOP)     state_next = ST_ENDING;
                end
                default:   if (button_bus == BTN_RESUME) state_next = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_START;
            setting_reg   <= SET_PEOPLE;
            people_reg    <= NUM_W'(DEF_PEOPLE);
            algorithm_reg <= '0;
            speed_reg     <= SPEED_W'(DEF_SPEED);
            commit_reg    <= 1'b0;
            timeout_reg   <= 1'b0;
            pressed_q     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            setting_reg   <= setting_next;
            people_reg    <= people_next;
            algorithm_reg <= algorithm_next;
            speed_reg     <= speed_next;
            commit_reg    <= commit_next;
            timeout_reg   <= timeout_fire;
            pressed_q     <= pressed;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt_reg;

    // A key press in the same cycle counts as activity and wins over expiry.
    assign timeout_fire = (idle_cnt_reg == TO_W'(TIMEOUT_CYC)) & ~key_evt & (number != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
        end else if (key_evt || (number == '0) || timeout_fire) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    digit_accumulator #(.NUM_W(NUM_W)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .limit  (limit),
        .add    (acc_add),
        .digit  (button_bus),
        .clear  (acc_clear),
        .number (number)
    );

    assign sim_state     = state_reg;
    assign setting       = setting_reg;
    assign people        = people_reg;
    assign algorithm     = algorithm_reg;
    assign sim_speed     = speed_reg;
    assign commit        = commit_reg;
    assign entry_timeout = timeout_reg;

endmodule

// File: tb/tb_central_config_fsm.sv
// Scoreboard bench for central_config_fsm: each key press pushes the expected outputs,
// which are popped and compared the cycle after the DUT sees the press edge.
module tb_central_config_fsm;

    localparam int TIMEOUT_CYC = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button_bus;
    logic       pressed;
    logic [1:0] sim_state, setting, algorithm;
    logic [5:0] people, number;
    logic [2:0] sim_speed;
    logic       commit, entry_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int key;
        int st;
        int set;
        int ppl;
        int alg;
        int spd;
        int num;
        int com;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int m_state, m_setting, m_people, m_algo, m_speed, m_number;

    logic prev_pressed, evt_seen, evt_d;

    central_config_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_bus    (button_bus),
        .pressed       (pressed),
        .sim_state     (sim_state),
        .setting       (setting),
        .people        (people),
        .algorithm     (algorithm),
        .sim_speed     (sim_speed),
        .number        (number),
        .commit        (commit),
        .entry_timeout (entry_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_setting = 0; m_people = 8; m_algo = 0; m_speed = 1; m_number = 0;
    endtask

    // Reference behaviour for one press edge; pushes the post-event expectation.
    task automatic model_key(input int key);
        int cand, lim, com;
        com = 0;
        if (m_state == 0) begin
            if (key <= 9) begin
                lim  = (m_setting == 0) ? 40 : (m_setting == 1) ? 3 : 7;
                cand = m_number * 10 + key;
                if (cand <= lim) m_number = cand;
            end else if (key == 11) begin
                m_state = 1; m_number = 0;
            end else if (key == 12) begin
                m_setting = (m_setting + 1) % 3; m_number = 0;
            end else if (key == 13) begin
                m_setting = (m_setting == 0) ? 2 : m_setting - 1; m_number = 0;
            end else if (key == 14) begin
                m_number = 0;
            end else if (key == 15) begin
                if (m_setting == 0)      m_people = m_number;
                else if (m_setting == 1) m_algo   = m_number;
                else                     m_speed  = m_number;
                m_number = 0; com = 1;
            end
        end else if (m_state == 1) begin
            if (key == 10) m_state = 2;
        end else if (m_state == 2) begin
            if (key == 11)      m_state = 1;
            else if (key == 10) m_state = 3;
        end else begin
            if (key == 11) m_state = 0;
        end
        exp_q.push_back('{key, m_state, m_setting, m_people, m_algo, m_speed, m_number, com});
    endtask

    task automatic press(input int key, input int hold);
        model_key(key);
        @(negedge clk);
        button_bus = 4'(key);
        pressed    = 1'b1;
        repeat (hold) @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pressed <= 1'b0;
            evt_seen     <= 1'b0;
            evt_d        <= 1'b0;
        end else begin
            prev_pressed <= pressed;
            evt_seen     <= pressed & ~prev_pressed;
            evt_d        <= evt_seen;
        end
    end

    always @(negedge clk) begin
        if (rst_n && evt_seen) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_event", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                $display("txn key=%h state=%0d setting=%0d people=%0d algo=%0d speed=%0d number=%0d commit=%0d",
                         cur.key, sim_state, setting, people, algorithm, sim_speed, number, commit);
                check_val("sim_state", int'(sim_state), cur.st);
                check_val("setting",   int'(setting),   cur.set);
                check_val("people",    int'(people),    cur.ppl);
                check_val("algorithm", int'(algorithm), cur.alg);
                check_val("sim_speed", int'(sim_speed), cur.spd);
                check_val("number",    int'(number),    cur.num);
                check_val("commit",    int'(commit),    cur.com);
                check_val("entry_timeout_evt", int'(entry_timeout), 0);
            end
        end
        if (rst_n && evt_d) check_val("commit_one_cycle", int'(commit), 0);
    end

    initial begin
        int pulses;
        int found;
        rst_n = 1'b0; pressed = 1'b0; button_bus = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_state",   int'(sim_state), 0);
        check_val("rst_setting", int'(setting),   0);
        check_val("rst_people",  int'(people),    8);
        check_val("rst_algo",    int'(algorithm), 0);
        check_val("rst_speed",   int'(sim_speed), 1);
        check_val("rst_number",  int'(number),    0);
        check_val("rst_commit",  int'(commit),    0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        press(3, 1); press(5, 1); press(15, 1);
        check_val("people_35", int'(people), 35);
        press(4, 2); press(5, 1); press(15, 1);
        check_val("people_4_saturated", int'(people), 4);
        press(12, 1); press(12, 1); press(9, 1); press(6, 1); press(15, 1);
        check_val("speed_6", int'(sim_speed), 6);
        press(12, 1);
        check_val("up_wraps_to_people", int'(setting), 0);
        press(13, 1);
        check_val("down_wraps_to_speed", int'(setting), 2);
        press(13, 1); press(5, 1); press(2, 1); press(15, 1);
        check_val("algo_2", int'(algorithm), 2);
        press(1, 1); press(14, 1); press(10, 1);
        press(13, 1); press(7, 1); press(11, 1);
        check_val("resume_discards", int'(number), 0);
        press(11, 1); press(10, 1); press(4, 1); press(10, 1);
        check_val("ending", int'(sim_state), 3);
        press(11, 1);
        check_val("settings_survive", int'(people), 4);

        // Held key with the code changing mid-hold must yield one event only.
        model_key(11);
        @(negedge clk);
        button_bus = 4'hB; pressed = 1'b1;
        repeat (10) @(negedge clk);
        button_bus = 4'hA;
        repeat (10) @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
        check_val("held_single_transition", int'(sim_state), 1);
        press(10, 1); press(10, 1); press(11, 1);

        press(14, 1); press(2, 1);
        pulses = 0; found = 0;
`ifdef ENTRY_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYC + 20 && found == 0; i++) begin
            @(negedge clk);
            if (entry_timeout) found = 1;
        end
        check_val("timeout_pulse_seen", found, 1);
        check_val("timeout_number_cleared", int'(number), 0);
        m_number = 0;
`else
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (entry_timeout) pulses++;
        end
        check_val("no_timeout_pulse", pulses, 0);
        check_val("number_held", int'(number), m_number);
`endif

        // Asynchronous reset in the middle of an entry.
        press(1, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_number", int'(number),    0);
        check_val("async_rst_people", int'(people),    8);
        check_val("async_rst_speed",  int'(sim_speed), 1);
        check_val("async_rst_state",  int'(sim_state), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            press(int'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
        end
        repeat (3) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
